// File: rtl/wb_arbiter_2m1s_pkg.sv
// Shared types and bus widths for the two-master Wishbone arbiter.
package wb_arbiter_2m1s_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT0  = 2'd1,
    ST_GNT1  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/wb_arbiter_2m1s_rr_pick2.sv
// Combinational 2-way round-robin pick: on contention the master that was not granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);

  assign valid = |req;
  assign gnt   = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/wb_arbiter_2m1s.sv
// Two-master to one-slave pipelined Wishbone arbiter with grant held per master cycle.
// Optional bus-hang timeout is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m1s
  import wb_arbiter_2m1s_pkg::*;
#(
  parameter int MAX_OUTST   = 4,
  parameter int OUTST_W     = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             m0_wb_cyc_i,
  input  logic             m0_wb_stb_i,
  input  logic             m0_wb_we_i,
  input  logic [WB_AW-1:0] m0_wb_adr_i,
  input  logic [WB_DW-1:0] m0_wb_dat_i,
  input  logic [WB_SW-1:0] m0_wb_sel_i,
  output logic             m0_wb_stall_o,
  output logic             m0_wb_ack_o,
  output logic             m0_wb_err_o,
  output logic [WB_DW-1:0] m0_wb_dat_o,
  input  logic             m1_wb_cyc_i,
  input  logic             m1_wb_stb_i,
  input  logic             m1_wb_we_i,
  input  logic [WB_AW-1:0] m1_wb_adr_i,
  input  logic [WB_DW-1:0] m1_wb_dat_i,
  input  logic [WB_SW-1:0] m1_wb_sel_i,
  output logic             m1_wb_stall_o,
  output logic             m1_wb_ack_o,
  output logic             m1_wb_err_o,
  output logic [WB_DW-1:0] m1_wb_dat_o,
  output logic             s_wb_cyc_o,
  output logic             s_wb_stb_o,
  output logic             s_wb_we_o,
  output logic [WB_AW-1:0] s_wb_adr_o,
  output logic [WB_DW-1:0] s_wb_dat_o,
  output logic [WB_SW-1:0] s_wb_sel_o,
  input  logic             s_wb_stall_i,
  input  logic             s_wb_ack_i,
  input  logic             s_wb_err_i,
  input  logic [WB_DW-1:0] s_wb_dat_i
);

  if (MAX_OUTST >= (1 << OUTST_W) || TIMEOUT_CYC < 2) begin : g_param_check
    $error("wb_arbiter_2m1s: OUTST_W too narrow for MAX_OUTST or TIMEOUT_CYC < 2");
  end

  localparam logic [OUTST_W-1:0] OUTST_MAX = OUTST_W'(MAX_OUTST);

  arb_state_e         state;
  logic               last_gnt;
  logic [OUTST_W-1:0] outst;
  logic [OUTST_W-1:0] outst_next;
  logic               pick_gnt;
  logic               pick_valid;
  logic               at_limit;
  logic               live;
  logic               acc;
  logic               rsp;
  logic               tmo_fire;

  rr_pick2 u_pick (
    .req   ({m1_wb_cyc_i & m1_wb_stb_i, m0_wb_cyc_i & m0_wb_stb_i}),
    .last  (last_gnt),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  assign at_limit    = (outst == OUTST_MAX);
  assign live        = (outst != '0);
  assign acc         = s_wb_stb_o & ~s_wb_stall_i;
  // Responses with nothing outstanding are spurious and must not move the counter.
  assign rsp         = (s_wb_ack_i | s_wb_err_i) & live;
  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    s_wb_cyc_o    = 1'b0;
    s_wb_stb_o    = 1'b0;
    s_wb_we_o     = 1'b0;
    s_wb_adr_o    = '0;
    s_wb_dat_o    = '0;
    s_wb_sel_o    = '0;
    m0_wb_stall_o = 1'b1;
    m0_wb_ack_o   = 1'b0;
    m0_wb_err_o   = 1'b0;
    m1_wb_stall_o = 1'b1;
    m1_wb_ack_o   = 1'b0;
    m1_wb_err_o   = 1'b0;
    unique case (state)
      ST_GNT0: begin
        s_wb_cyc_o    = m0_wb_cyc_i | live;
        s_wb_stb_o    = m0_wb_cyc_i & m0_wb_stb_i & ~at_limit;
        s_wb_we_o     = m0_wb_we_i;
        s_wb_adr_o    = m0_wb_adr_i;
        s_wb_dat_o    = m0_wb_dat_i;
        s_wb_sel_o    = m0_wb_sel_i;
        m0_wb_stall_o = s_wb_stall_i | at_limit;
        m0_wb_ack_o   = s_wb_ack_i & live;
        m0_wb_err_o   = (s_wb_err_i & live) | tmo_fire;
      end
      ST_GNT1: begin
        s_wb_cyc_o    = m1_wb_cyc_i | live;
        s_wb_stb_o    = m1_wb_cyc_i & m1_wb_stb_i & ~at_limit;
        s_wb_we_o     = m1_wb_we_i;
        s_wb_adr_o    = m1_wb_adr_i;
        s_wb_dat_o    = m1_wb_dat_i;
        s_wb_sel_o    = m1_wb_sel_i;
        m1_wb_stall_o = s_wb_stall_i | at_limit;
        m1_wb_ack_o   = s_wb_ack_i & live;
        m1_wb_err_o   = (s_wb_err_i & live) | tmo_fire;
      end
      ST_DRAIN: s_wb_cyc_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    outst_next = outst;
    if (acc && !rsp)      outst_next = outst + OUTST_W'(1);
    else if (rsp && !acc) outst_next = outst - OUTST_W'(1);
  end

  // last_gnt is updated at grant time; it is only consulted in IDLE, after the grant has ended.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state    <= ST_IDLE;
      last_gnt <= 1'b1;
      outst    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
      outst <= outst_next;
      unique case (state)
        ST_IDLE: if (pick_valid) begin
          state    <= pick_gnt ? ST_GNT1 : ST_GNT0;
          last_gnt <= pick_gnt;
        end
        ST_GNT0:  if (!m0_wb_cyc_i) state <= (outst_next == '0) ? ST_IDLE : ST_DRAIN;
        ST_GNT1:  if (!m1_wb_cyc_i) state <= (outst_next == '0) ? ST_IDLE : ST_DRAIN;
        ST_DRAIN: if (outst_next == '0) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
      if (tmo_fire) begin
        state <= ST_IDLE;
        outst <= '0;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int             TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                                              tmo_cnt <= '0;
    else if (state == ST_IDLE || s_wb_ack_i || s_wb_err_i || tmo_fire) tmo_cnt <= '0;
    else if (live)                                               tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  // Fires in the TIMEOUT_CYC-th consecutive cycle with work outstanding and no response.
  assign tmo_fire = (state != ST_IDLE) && live && (tmo_cnt == TMO_LAST);
`else
  assign tmo_fire = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_2m1s.sv
// Directed testbench for wb_arbiter_2m1s with a pipelined RAM responder that can withhold acks.
module tb_wb_arbiter_2m1s;

  logic        clk, rst_n;
  logic        m0_cyc, m0_stb, m0_we, m0_stall, m0_ack, m0_err;
  logic [31:0] m0_adr, m0_wdat, m0_dat;
  logic [3:0]  m0_sel;
  logic        m1_cyc, m1_stb, m1_we, m1_stall, m1_ack, m1_err;
  logic [31:0] m1_adr, m1_wdat, m1_dat;
  logic [3:0]  m1_sel;
  logic        s_cyc, s_stb, s_we, s_stall, s_err;
  logic [31:0] s_adr, s_wdat;
  logic [3:0]  s_sel;

  logic        hold, spur_ack, ack_q;
  logic [31:0] rdat;
  logic [31:0] rq[$];
  logic [31:0] m0_rx[$];
  logic [31:0] m1_rx[$];
  int          m0_errs, s_acks;
  int          checks, failures;

  wb_arbiter_2m1s #(.MAX_OUTST(4), .OUTST_W(3), .TIMEOUT_CYC(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we), .m0_wb_adr_i(m0_adr),
    .m0_wb_dat_i(m0_wdat), .m0_wb_sel_i(m0_sel), .m0_wb_stall_o(m0_stall), .m0_wb_ack_o(m0_ack),
    .m0_wb_err_o(m0_err), .m0_wb_dat_o(m0_dat),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we), .m1_wb_adr_i(m1_adr),
    .m1_wb_dat_i(m1_wdat), .m1_wb_sel_i(m1_sel), .m1_wb_stall_o(m1_stall), .m1_wb_ack_o(m1_ack),
    .m1_wb_err_o(m1_err), .m1_wb_dat_o(m1_dat),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we), .s_wb_adr_o(s_adr),
    .s_wb_dat_o(s_wdat), .s_wb_sel_o(s_sel),
    .s_wb_stall_i(s_stall), .s_wb_ack_i(ack_q | spur_ack), .s_wb_err_i(s_err), .s_wb_dat_i(rdat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ram_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
  endfunction

  // RAM responder: accepted strobes queue up; one ack per cycle while hold is low.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      rdat  <= '0;
      rq.delete();
    end else if (!s_cyc) begin
      ack_q <= 1'b0;
      rq.delete();
    end else begin
      if (s_stb && !s_stall) rq.push_back(ram_data(s_adr));
      if (!hold && rq.size() > 0) begin
        ack_q <= 1'b1;
        rdat  <= rq.pop_front();
      end else begin
        ack_q <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m0_ack) m0_rx.push_back(m0_dat);
    if (m1_ack) m1_rx.push_back(m1_dat);
    if (m0_err) m0_errs++;
    if (s_cyc && (ack_q || spur_ack)) s_acks++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    step;
    step;
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack, m0_err, m1_err} !== 8'b0011_0000) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 00110000",
               {s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack, m0_err, m1_err});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step;
    #2;
    checks++;
    if ({s_cyc, s_stb, m0_stall, m1_stall} !== 4'b0011) begin
      failures++;
      $display("FAIL idle_after_reset: got %b expected 0011", {s_cyc, s_stb, m0_stall, m1_stall});
    end
  endtask

  task automatic test_single_read;
    int b1;
    b1 = m1_rx.size();
    step;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h100;
    #2;
    checks++;
    if ({s_stb, m0_stall} !== 2'b01) begin
      failures++;
      $display("FAIL read_T_stalled: got stb,stall=%b expected 01", {s_stb, m0_stall});
    end
    step;
    #2;
    checks++;
    if ({s_stb, m0_stall, m1_stall} !== 3'b101 || s_adr !== 32'h100) begin
      failures++;
      $display("FAIL read_T1_strobe: got stb,st0,st1=%b adr=%h expected 101 adr=00000100",
               {s_stb, m0_stall, m1_stall}, s_adr);
    end
    step;
    m0_stb = 1'b0;
    #2;
    checks++;
    if (m0_ack !== 1'b1 || m0_dat !== 32'hDEADBEEF || m1_ack !== 1'b0) begin
      failures++;
      $display("FAIL read_T2_ack: got ack0=%b dat=%h ack1=%b expected 1 deadbeef 0", m0_ack, m0_dat, m1_ack);
    end
    step;
    m0_cyc = 1'b0;
    step;
    #2;
    checks++;
    if (s_cyc !== 1'b0 || m1_rx.size() != b1) begin
      failures++;
      $display("FAIL read_release: got s_cyc=%b m1_acks=%0d expected 0 and %0d", s_cyc, m1_rx.size(), b1);
    end
  endtask

  task automatic test_alternation;
    apply_reset;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h10;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h20;
    step;
    #2;
    checks++;
    if ({m0_stall, m1_stall} !== 2'b01 || s_adr !== 32'h10) begin
      failures++;
      $display("FAIL alt_first_m0: got st0,st1=%b adr=%h expected 01 adr=00000010", {m0_stall, m1_stall}, s_adr);
    end
    step;
    m0_stb = 1'b0;
    step;
    m0_cyc = 1'b0;
    step;
    #2;
    checks++;
    if (m1_stall !== 1'b1) begin
      failures++;
      $display("FAIL alt_idle_stall: got m1_stall=%b expected 1", m1_stall);
    end
    step;
    #2;
    checks++;
    if ({m0_stall, m1_stall} !== 2'b10 || s_adr !== 32'h20) begin
      failures++;
      $display("FAIL alt_then_m1: got st0,st1=%b adr=%h expected 10 adr=00000020", {m0_stall, m1_stall}, s_adr);
    end
    step;
    m1_stb = 1'b0;
    #2;
    checks++;
    if (m1_ack !== 1'b1 || m1_dat !== 32'hC0DE0020) begin
      failures++;
      $display("FAIL alt_m1_ack: got ack=%b dat=%h expected 1 c0de0020", m1_ack, m1_dat);
    end
    step;
    m1_cyc = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h14;
    step;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h24;
    step;
    #2;
    checks++;
    if ({m0_stall, m1_stall} !== 2'b01 || s_adr !== 32'h14) begin
      failures++;
      $display("FAIL alt_back_to_m0: got st0,st1=%b adr=%h expected 01 adr=00000014", {m0_stall, m1_stall}, s_adr);
    end
    step;
    m0_stb = 1'b0;
    step;
    m0_cyc = 1'b0;
    step;
    step;
    #2;
    checks++;
    if (m1_stall !== 1'b0 || s_adr !== 32'h24) begin
      failures++;
      $display("FAIL alt_m1_again: got st1=%b adr=%h expected 0 adr=00000024", m1_stall, s_adr);
    end
    step;
    m1_stb = 1'b0;
    step;
    m1_cyc = 1'b0;
    step;
  endtask

  task automatic test_outstanding;
    int sent, guard, b0, b1;
    b0 = m0_rx.size();
    b1 = m1_rx.size();
    step;
    hold = 1'b1; s_stall = 1'b1;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h200;
    step;
    #2;
    checks++;
    if ({s_stb, m1_stall} !== 2'b11) begin
      failures++;
      $display("FAIL outst_slave_stall: got stb,stall=%b expected 11", {s_stb, m1_stall});
    end
    step;
    s_stall = 1'b0;
    sent = 0;
    guard = 0;
    while (sent < 6 && guard < 60) begin
      m1_adr = 32'h200 + 32'(4 * sent);
      #2;
      if (sent == 4 && hold) begin
        checks++;
        if ({s_stb, m1_stall} !== 2'b01) begin
          failures++;
          $display("FAIL outst_limit_stall: got stb,stall=%b expected 01", {s_stb, m1_stall});
        end
        hold = 1'b0;
      end
      if (!m1_stall) sent++;
      step;
      guard++;
    end
    m1_stb = 1'b0;
    guard = 0;
    while (m1_rx.size() < b1 + 6 && guard < 40) begin
      step;
      guard++;
    end
    checks++;
    if (m1_rx.size() != b1 + 6) begin
      failures++;
      $display("FAIL outst_ack_count: got %0d acks expected 6", m1_rx.size() - b1);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (m1_rx[b1 + i] !== ram_data(32'h200 + 32'(4 * i))) begin
          failures++;
          $display("FAIL outst_order_%0d: got %h expected %h", i, m1_rx[b1 + i], ram_data(32'h200 + 32'(4 * i)));
        end
      end
    end
    m1_cyc = 1'b0;
    step;
    #2;
    checks++;
    if (s_cyc !== 1'b0 || m0_rx.size() != b0) begin
      failures++;
      $display("FAIL outst_end_zero: got s_cyc=%b m0_acks=%0d expected 0 and %0d", s_cyc, m0_rx.size(), b0);
    end
  endtask

  task automatic test_abort;
    int sent, guard, b0, sa;
    b0 = m0_rx.size();
    step;
    hold = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h500;
    sent = 0;
    guard = 0;
    while (sent < 2 && guard < 20) begin
      m0_adr = 32'h400 + 32'(4 * sent);
      #2;
      if (!m0_stall) sent++;
      step;
      guard++;
    end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    #2;
    checks++;
    if (s_stb !== 1'b0 || sent != 2) begin
      failures++;
      $display("FAIL abort_drop: got s_stb=%b sent=%0d expected 0 and 2", s_stb, sent);
    end
    step;
    sa = s_acks;
    #2;
    checks++;
    if ({s_cyc, s_stb, m0_stall, m1_stall} !== 4'b1011) begin
      failures++;
      $display("FAIL abort_drain: got cyc,stb,st0,st1=%b expected 1011", {s_cyc, s_stb, m0_stall, m1_stall});
    end
    hold = 1'b0;
    guard = 0;
    do begin
      step;
      #2;
      guard++;
    end while (m1_stall && guard < 20);
    checks++;
    if (m1_stall !== 1'b0 || s_adr !== 32'h500) begin
      failures++;
      $display("FAIL abort_m1_grant: got st1=%b adr=%h expected 0 adr=00000500", m1_stall, s_adr);
    end
    checks++;
    if (m0_rx.size() != b0 || s_acks - sa != 2) begin
      failures++;
      $display("FAIL abort_swallow: got m0_acks=%0d slave_acks=%0d expected 0 and 2", m0_rx.size() - b0, s_acks - sa);
    end
    step;
    m1_stb = 1'b0;
    #2;
    checks++;
    if (m1_ack !== 1'b1 || m1_dat !== 32'hC0DE0500) begin
      failures++;
      $display("FAIL abort_m1_ack: got ack=%b dat=%h expected 1 c0de0500", m1_ack, m1_dat);
    end
    step;
    m1_cyc = 1'b0;
    step;
  endtask

  task automatic test_spurious;
    int b0;
    b0 = m0_rx.size();
    step;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h600;
    step;
    spur_ack = 1'b1;
    #2;
    checks++;
    if (m0_ack !== 1'b0) begin
      failures++;
      $display("FAIL spur_blocked: got m0_ack=%b expected 0", m0_ack);
    end
    step;
    spur_ack = 1'b0;
    m0_stb = 1'b0;
    #2;
    checks++;
    if (m0_ack !== 1'b1 || m0_dat !== 32'hC0DE0600) begin
      failures++;
      $display("FAIL spur_real_ack: got ack=%b dat=%h expected 1 c0de0600", m0_ack, m0_dat);
    end
    step;
    m0_cyc = 1'b0;
    step;
    #2;
    checks++;
    if (s_cyc !== 1'b0 || m0_rx.size() != b0 + 1) begin
      failures++;
      $display("FAIL spur_no_underflow: got s_cyc=%b acks=%0d expected 0 and 1", s_cyc, m0_rx.size() - b0);
    end
  endtask

  task automatic test_reset_mid;
    int sent, guard;
    step;
    hold = 1'b1;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    sent = 0;
    guard = 0;
    while (sent < 3 && guard < 20) begin
      m1_adr = 32'h700 + 32'(4 * sent);
      #2;
      if (!m1_stall) sent++;
      step;
      guard++;
    end
    m1_stb = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack} !== 6'b001100 || sent != 3) begin
      failures++;
      $display("FAIL midreset_outputs: got %b sent=%0d expected 001100 and 3",
               {s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack}, sent);
    end
    hold = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h800;
    m1_stb = 1'b1; m1_adr = 32'h704;
    step;
    rst_n = 1'b1;
    step;
    #2;
    checks++;
    if ({m0_stall, m1_stall} !== 2'b01 || s_adr !== 32'h800) begin
      failures++;
      $display("FAIL midreset_m0_first: got st0,st1=%b adr=%h expected 01 adr=00000800", {m0_stall, m1_stall}, s_adr);
    end
    step;
    m0_stb = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0;
    step;
    m0_cyc = 1'b0;
    step;
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int n, e0;
    e0 = m0_errs;
    step;
    hold = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h900;
    step;
    step;
    m0_stb = 1'b0;
    n = 1;
    #2;
    while (!m0_err && n < 20) begin
      step;
      n++;
      #2;
    end
    checks++;
    if (m0_err !== 1'b1 || n != 8) begin
      failures++;
      $display("FAIL timeout_err: got err=%b after %0d cycles expected 1 after 8", m0_err, n);
    end
    m0_cyc = 1'b0;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h904;
    step;
    #2;
    checks++;
    if (s_cyc !== 1'b0 || m0_errs != e0 + 1) begin
      failures++;
      $display("FAIL timeout_release: got s_cyc=%b errs=%0d expected 0 and 1", s_cyc, m0_errs - e0);
    end
    hold = 1'b0;
    step;
    #2;
    checks++;
    if (m1_stall !== 1'b0 || s_adr !== 32'h904) begin
      failures++;
      $display("FAIL timeout_m1_grant: got st1=%b adr=%h expected 0 adr=00000904", m1_stall, s_adr);
    end
    step;
    m1_stb = 1'b0;
    step;
    m1_cyc = 1'b0;
    step;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0; m0_errs = 0; s_acks = 0;
    rst_n = 1'b0; hold = 1'b0; spur_ack = 1'b0; s_stall = 1'b0; s_err = 1'b0;
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_wdat = '0; m0_sel = 4'hF;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_wdat = '0; m1_sel = 4'hF;
    test_reset;
    test_single_read;
    test_alternation;
    test_outstanding;
    test_abort;
    test_spurious;
    test_reset_mid;
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
